// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_RESP,
        RMW_WRITE
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, load extraction/extension and
// sub-word merge of store data into the memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ext_load,
    output logic [31:0] merged_word,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b      = rdata[{addr, 3'b000} +: 8];
        lane_h      = rdata[{addr[1], 4'b0000} +: 16];
        ext_load    = rdata;
        merged_word = rdata;
        misalign    = 1'b0;
        case (size_e'(size))
            SIZE_B: begin
                ext_load = {{24{~uns & lane_b[7]}}, lane_b};
                merged_word[{addr, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                ext_load = {{16{~uns & lane_h[15]}}, lane_h};
                merged_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
                misalign = addr[0];
            end
            SIZE_W: begin
                misalign = (addr != 2'b00);
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: word-aligned data-memory initiator with
// read-modify-write for byte/halfword stores.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state;
    logic [31:0] wbuf;
    logic [31:0] abuf;
    logic [31:0] ext_load;
    logic [31:0] merged_word;
    logic        bad;
    logic [31:0] word_addr;

    assign word_addr = {req_addr[31:2], 2'b00};

    lsu_align u_align (
        .addr        (req_addr[1:0]),
        .size        (req_size),
        .uns         (req_unsigned),
        .rdata       (mem_rdata),
        .wdata       (req_wdata),
        .ext_load    (ext_load),
        .merged_word (merged_word),
        .misalign    (bad)
    );

    always_comb begin
        stall      = 1'b0;
        load_valid = 1'b0;
        misalign   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad) begin
                        misalign = 1'b1;
                    end else if (req_we && req_size == SIZE_W) begin
                        mem_write = 1'b1;
                        mem_addr  = word_addr;
                        mem_wdata = req_wdata;
                    end else begin
                        mem_read = 1'b1;
                        mem_addr = word_addr;
                        stall    = 1'b1;
                    end
                end
            end
            LOAD_RESP: load_valid = 1'b1;
            RMW_WRITE: begin
                mem_write = 1'b1;
                mem_addr  = abuf;
                mem_wdata = wbuf;
            end
            default: ;
        endcase
        // Reset must cancel any in-flight write or load response immediately.
        if (!rst_n) begin
            stall      = 1'b0;
            load_valid = 1'b0;
            misalign   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            load_data <= '0;
            wbuf      <= '0;
            abuf      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !bad) begin
                        if (!req_we) begin
                            load_data <= ext_load;
                            state     <= LOAD_RESP;
                        end else if (req_size != SIZE_W) begin
                            wbuf  <= merged_word;
                            abuf  <= word_addr;
                            state <= RMW_WRITE;
                        end
                    end
                end
                LOAD_RESP: state <= IDLE;
                RMW_WRITE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan steps plus random traffic
// against a byte-addressed reference memory.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [64];
    logic [7:0]  rmem [256];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;
    logic        stall_log [$];

    lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .misalign     (misalign),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        else if (pl_we) mem[pl_idx] <= pl_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a[7:2]) * 4;
        return {rmem[b + 3], rmem[b + 2], rmem[b + 1], rmem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic uns);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(rmem[int'(a[7:0]) + i]) << (8 * i));
        if (!uns && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) rmem[int'(a[7:0]) + i] = wd[8 * i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        pl_we   = 1'b1;
        pl_idx  = a[7:2];
        pl_data = w;
        for (int i = 0; i < 4; i++) rmem[int'(a[7:2]) * 4 + i] = w[8 * i +: 8];
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, ".mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, ".misalign"}, 32'(misalign), 32'd0);
    endtask

    // One request, issued just after a rising edge; returns just after the last edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        logic        bad;
        logic [31:0] wa;
        int          n;
        wa  = {a[31:2], 2'b00};
        n   = 1 << sz;
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        stall_log.push_back(stall);
        chk("c1.load_valid", 32'(load_valid), 32'd0);
        if (bad) begin
            chk("mis.misalign", 32'(misalign), 32'd1);
            chk("mis.stall", 32'(stall), 32'd0);
            chk("mis.mem_read", 32'(mem_read), 32'd0);
            chk("mis.mem_write", 32'(mem_write), 32'd0);
            @(posedge clk); #1;
        end else if (we && sz == 2'd2) begin
            ref_store(a, 4, wd);
            chk("sw.mem_write", 32'(mem_write), 32'd1);
            chk("sw.mem_read", 32'(mem_read), 32'd0);
            chk("sw.stall", 32'(stall), 32'd0);
            chk("sw.mem_addr", mem_addr, wa);
            chk("sw.mem_wdata", mem_wdata, ref_word(wa));
            @(posedge clk); #1;
        end else begin
            chk("rd.mem_read", 32'(mem_read), 32'd1);
            chk("rd.mem_write", 32'(mem_write), 32'd0);
            chk("rd.stall", 32'(stall), 32'd1);
            chk("rd.mem_addr", mem_addr, wa);
            chk("rd.misalign", 32'(misalign), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            stall_log.push_back(stall);
            chk("c2.stall", 32'(stall), 32'd0);
            chk("c2.mem_read", 32'(mem_read), 32'd0);
            if (!we) begin
                chk("ld.load_valid", 32'(load_valid), 32'd1);
                chk("ld.load_data", load_data, ref_load(a, n, uns));
                chk("ld.mem_write", 32'(mem_write), 32'd0);
            end else begin
                ref_store(a, n, wd);
                chk("rmw.load_valid", 32'(load_valid), 32'd0);
                chk("rmw.mem_write", 32'(mem_write), 32'd1);
                chk("rmw.mem_addr", mem_addr, wa);
                chk("rmw.mem_wdata", mem_wdata, ref_word(wa));
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        logic [6:0] pat;
        rst_n = 1'b0; pl_we = 1'b0; pl_idx = '0; pl_data = '0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = '0;
        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
        preload(32'h20, 32'h80FF7F01);
        preload(32'h30, 32'h11223344);
        preload(32'h4C, 32'h01020304);

        // Reset state, with a load request held to show the gating.
        @(negedge clk);
        check_quiet("rst");
        chk("rst.load_valid", 32'(load_valid), 32'd0);
        chk("rst.load_data", load_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check_quiet("idle");
        chk("idle.mem_addr", mem_addr, 32'd0);
        chk("idle.mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("lw.deadbeef", load_data, 32'hDEADBEEF);

        issue(1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
        chk("lb@23", load_data, 32'hFFFFFF80);
        issue(1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
        chk("lbu@23", load_data, 32'h00000080);
        issue(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
        chk("lb@20", load_data, 32'h00000001);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        chk("lh@22", load_data, 32'hFFFF80FF);
        issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
        chk("lhu@20", load_data, 32'h00007F01);

        issue(1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA);
        chk("sb.mem", mem[12], 32'h1122AA44);
        issue(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF);
        chk("sh.mem", mem[12], 32'hBEEFAA44);

        issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        chk("mis.load_data_held", load_data, 32'h00007F01);

        // Reset during the write cycle of a byte store.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h77;
        @(negedge clk);
        chk("rstw.mem_read", 32'(mem_read), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("rstw");
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check_quiet("rstw.after");
        chk("rstw.load_valid", 32'(load_valid), 32'd0);
        chk("rstw.mem", mem[12], 32'hBEEFAA44);
        @(posedge clk); #1;
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);

        // Reset during the load response cycle.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstl.load_valid", 32'(load_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0;
        chk("rstl.load_data", load_data, 32'd0);

        // Back-to-back lb, sb, sw, lw.
        stall_log.delete();
        issue(1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h4D, 32'h0000005A);
        issue(1'b1, 2'd2, 1'b0, 32'h48, 32'hCAFEF00D);
        issue(1'b0, 2'd2, 1'b0, 32'h4C, 32'h0);
        chk("b2b.lw", load_data, 32'h01025A04);
        pat = '0;
        for (int i = 0; i < 7; i++) if (i < stall_log.size()) pat[6 - i] = stall_log[i];
        chk("b2b.stall_pattern", 32'(pat), 32'b1010010);
        chk("b2b.stall_count", stall_log.size(), 32'd7);
        issue(1'b0, 2'd2, 1'b0, 32'h48, 32'h0);
        chk("b2b.sw", load_data, 32'hCAFEF00D);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                check_quiet("rnd.idle");
                @(posedge clk); #1;
            end
            issue(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)), $urandom);
        end

        for (int i = 0; i < 64; i++) chk("final.mem", mem[i], ref_word(32'(i * 4)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the MEM stage of the pipeline: the initiator side of the word-wide data memory. It turns byte, halfword and word load/store requests into word-aligned reads and writes on the data-memory port. Stores narrower than a word use read-modify-write, because the memory writes whole words only. The unit stalls the pipeline while a multi-cycle access is in flight.

## Interface
Parameters: none (32-bit address/data fixed).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  MEM-stage instruction is a load or store
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (lbu/lhu); ignored for word and stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  hold pipeline this cycle
- load_valid  out  1  load_data valid this cycle
- load_data  out  32  extended load result (registered)
- misalign  out  1  request rejected (misaligned or illegal size), combinational pulse
- mem_read  out  1  data-memory read enable
- mem_write  out  1  data-memory write enable
- mem_addr  out  32  word-aligned address, bits [1:0] always 00
- mem_wdata  out  32  full write word
- mem_rdata  in  32  combinational read data from memory

## Operation
- FSM states: IDLE, LOAD_RESP, RMW_WRITE. Requests are sampled only in IDLE. In other states the req_* inputs are ignored; the upstream stage holds them stable while stall=1.
- Misalignment check (IDLE): halfword with addr[0]=1, word with addr[1:0]≠00, or size 11.
  - Result: misalign=1, no mem_read/mem_write, stall=0, stay IDLE.
- Load (IDLE, aligned):
  - Drive mem_read=1, mem_addr={addr[31:2],00}, stall=1.
  - Register the extracted, extended value into load_data. Go to LOAD_RESP.
- LOAD_RESP: load_valid=1, stall=0, go to IDLE.
- Word store (IDLE, aligned): mem_write=1, mem_wdata=req_wdata, stall=0, stay IDLE. Single cycle.
- Sub-word store (IDLE, aligned):
  - Drive mem_read=1, stall=1.
  - Register the merged word into wbuf and the word address into abuf. Go to RMW_WRITE.
- RMW_WRITE: mem_write=1, mem_addr=abuf, mem_wdata=wbuf, stall=0, go to IDLE.
- Extraction:
  - Byte: lane=addr[1:0], data=mem_rdata[8·lane+7:8·lane].
  - Halfword: data=mem_rdata[16·addr[1]+15:16·addr[1]].
  - Sign-extend from bit 7 or bit 15 unless req_unsigned=1.
- Merge: replace the addressed byte or halfword of mem_rdata with req_wdata[7:0] or req_wdata[15:0]. All other bytes are unchanged.
- IDLE with req_valid=0: all mem_* outputs and stall are 0.

## Timing
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; load_data, load_valid, wbuf, abuf all 0.
  - mem_read, mem_write, stall and misalign are forced to 0 combinationally while rst_n=0.
- Reset mid-operation:
  - rst_n low during RMW_WRITE: the write is suppressed.
  - rst_n low during LOAD_RESP: load_valid=0.
- Latency:
  - Word store: 1 cycle, no stall.
  - Load: 2 cycles, 1 stall cycle; load_valid is asserted in the cycle after issue.
  - Sub-word store: 2 cycles, 1 stall cycle; the write commits at the end of the second cycle.
- Back-to-back: a new request is accepted in the cycle after LOAD_RESP or RMW_WRITE. No overlap and no forwarding between requests.
- load_data holds its value until the next load completes. load_valid is a 1-cycle pulse.

## Structure
- lsu_pkg holds:
  - size_e enum: SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
  - state_e enum: IDLE, LOAD_RESP, RMW_WRITE.
- Sub-module lsu_align: purely combinational. Inputs: addr[1:0], size, unsigned, rdata, wdata. Outputs: ext_load, merged_word, misalign. lsu holds the FSM and registers only.

## Test plan
- Word store then load: sw 0xDEADBEEF @0x10, then lw @0x10.
  - Store: mem_write in 1 cycle, stall=0.
  - Load: stall=1 for 1 cycle, then load_valid=1 with load_data=0xDEADBEEF.
- Byte load extension: memory word 0x80FF7F01 @0x20.
  - lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080; lb @0x20 → 0x00000001.
  - lh @0x22 → 0xFFFF80FF; lhu @0x20 → 0x00007F01.
- Sub-word store RMW: word 0x11223344 @0x30.
  - sb 0xAA @0x31 → read cycle, then write cycle with mem_wdata=0x1122AA44.
  - sh 0xBEEF @0x32 → 0xBEEFAA44 (applied after the sb).
- Misalignment:
  - lw @0x12 → misalign=1 for 1 cycle, no mem_read/mem_write, stall=0.
  - Same result for lh @0x11 and for req_size=11.
- Reset in RMW_WRITE: drop rst_n during the write cycle of sb @0x30.
  - mem_write stays 0, the memory word is unchanged, state returns to IDLE, all outputs are 0.
- Back-to-back: lb, sb, sw, lw on consecutive instructions.
  - Stall pattern: 1,0,1,0,0,1,0.
  - The final lw returns the value written by the sb/sw.
